// File: rtl/alu_arb_pkg.sv
// Shared definitions for the alu arbiter slice: FSM state encoding,
// alu function-select opcodes and flag bit positions.
package alu_arb_pkg;

    // Arbiter FSM states; ST_BAD is unreachable and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2,
        ST_BAD  = 2'd3
    } arb_state_t;

    // alu function-select opcodes; unlisted codes pass operand A through.
    localparam logic [2:0] FS_ADD = 3'b000;
    localparam logic [2:0] FS_SUB = 3'b001;
    localparam logic [2:0] FS_AND = 3'b010;
    localparam logic [2:0] FS_OR  = 3'b011;
    localparam logic [2:0] FS_XOR = 3'b100;

    // Bit positions inside the {C,V,N,Z} flag vector.
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit alu shared by the arbiter.
// Ports: a, b (operands), fs (function select) -> y (result), flags {C,V,N,Z}.
// SUB computes a + ~b + 1, so C=1 means "no borrow" (a >= b unsigned).
module alu
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int FS_W   = 3
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [FS_W-1:0]   fs,
    output logic [DATA_W-1:0] y,
    output logic [3:0]        flags
);

    logic [DATA_W:0] wide_s;
    logic            c_s;
    logic            v_s;

    // Result, carry and signed-overflow for the selected function.
    always_comb begin
        wide_s = {(DATA_W+1){1'b0}};
        y      = {DATA_W{1'b0}};
        c_s    = 1'b0;
        v_s    = 1'b0;
        case (fs)
            FS_ADD: begin
                wide_s = {1'b0, a} + {1'b0, b};
                y      = wide_s[DATA_W-1:0];
                c_s    = wide_s[DATA_W];
                v_s    = (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
            end
            FS_SUB: begin
                wide_s = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
                y      = wide_s[DATA_W-1:0];
                c_s    = wide_s[DATA_W];
                v_s    = (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
            end
            FS_AND:  y = a & b;
            FS_OR:   y = a | b;
            FS_XOR:  y = a ^ b;
            default: y = a;
        endcase
    end

    // Pack the flag vector by named bit position.
    always_comb begin
        flags         = 4'b0000;
        flags[FLAG_C] = c_s;
        flags[FLAG_V] = v_s;
        flags[FLAG_N] = y[DATA_W-1];
        flags[FLAG_Z] = ~|y;
    end

endmodule

// File: rtl/alu_rr_pick.sv
// Round-robin pick between two requesters.
// Ports: valid[1:0] (request vector), ptr (requester favoured on a tie)
//        -> grant[1:0] (one-hot, or zero when nobody requests).
module alu_rr_pick (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    // A lone requester always wins; ptr only breaks a tie.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational alu between requesters r0 and r1.
// Ports: clk, rst (async active-high); r0_*/r1_* valid/ready request channels
//        with operands a, b and function select fs; resp_* response channel
//        (valid/ready, id, y, flags {C,V,N,Z}); busy = FSM not idle.
// Each op walks IDLE (grant) -> EXEC (alu evaluates latched operands)
// -> RESP (hold result until consumed).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int FS_W      = 3,
    parameter int PRIO_INIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic [FS_W-1:0]   r0_fs,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic [FS_W-1:0]   r1_fs,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_y,
    output logic [3:0]        resp_flags,
    output logic              busy
);

    arb_state_t        state_r;
    logic              ptr_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [FS_W-1:0]   fs_r;
    logic              id_r;
    logic [DATA_W-1:0] resp_y_r;
    logic [3:0]        resp_flags_r;

    logic [1:0]        pick_s;
    logic [1:0]        grant_s;
    logic [DATA_W-1:0] sel_a_s;
    logic [DATA_W-1:0] sel_b_s;
    logic [FS_W-1:0]   sel_fs_s;
    logic [DATA_W-1:0] alu_y_s;
    logic [3:0]        alu_flags_s;

    alu_rr_pick u_pick (
        .valid (({r1_valid, r0_valid})),
        .ptr   (ptr_r),
        .grant (pick_s)
    );

    alu #(
        .DATA_W (DATA_W),
        .FS_W   (FS_W)
    ) u_alu (
        .a     (a_r),
        .b     (b_r),
        .fs    (fs_r),
        .y     (alu_y_s),
        .flags (alu_flags_s)
    );

    // Grants exist only while idle; the granted requester's fields feed the operand regs.
    always_comb begin
        grant_s  = 2'b00;
        sel_a_s  = r0_a;
        sel_b_s  = r0_b;
        sel_fs_s = r0_fs;
        if (state_r == ST_IDLE) begin
            grant_s = pick_s;
        end else begin
            grant_s = 2'b00;
        end
        if (grant_s[1]) begin
            sel_a_s  = r1_a;
            sel_b_s  = r1_b;
            sel_fs_s = r1_fs;
        end else begin
            sel_a_s  = r0_a;
            sel_b_s  = r0_b;
            sel_fs_s = r0_fs;
        end
    end

    assign r0_ready   = grant_s[0];
    assign r1_ready   = grant_s[1];
    assign resp_valid = (state_r == ST_RESP);
    assign busy       = (state_r != ST_IDLE);
    assign resp_id    = id_r;
    assign resp_y     = resp_y_r;
    assign resp_flags = resp_flags_r;

    // Arbiter FSM with operand, result and priority registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            ptr_r        <= 1'(PRIO_INIT);
            a_r          <= {DATA_W{1'b0}};
            b_r          <= {DATA_W{1'b0}};
            fs_r         <= {FS_W{1'b0}};
            id_r         <= 1'b0;
            resp_y_r     <= {DATA_W{1'b0}};
            resp_flags_r <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|grant_s) begin
                        a_r     <= sel_a_s;
                        b_r     <= sel_b_s;
                        fs_r    <= sel_fs_s;
                        id_r    <= grant_s[1];
                        state_r <= ST_EXEC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    resp_y_r     <= alu_y_s;
                    resp_flags_r <= alu_flags_s;
                    state_r      <= ST_RESP;
                end
                ST_RESP: begin
                    // The other requester gets the next tie.
                    if (resp_ready) begin
                        ptr_r   <= ~id_r;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule
